// File: rtl/nios_pk_pkg.sv
// Shared definitions for the Nios-to-ReCOP packet output port: register map,
// handshake state encoding and STATUS bit positions.
package nios_pk_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_COUNT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } hs_state_t;

    localparam int ST_BUSY = 0;
    localparam int ST_OVR  = 1;
    localparam int ST_TMO  = 2;

endpackage

// File: rtl/nios_pk_hs_fsm.sv
// Four-phase valid/ack handshake toward ReCOP with an optional REQ timeout.
// done and timeout are single-cycle pulses aligned with the edge that leaves REQ.
module nios_pk_hs_fsm
    import nios_pk_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic out_ack,
    output logic out_valid,
    output logic busy,
    output logic done,
    output logic timeout
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    hs_state_t     state_reg, state_next;
    logic          valid_reg, valid_next;
    logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            valid_reg   <= 1'b0;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            valid_reg   <= valid_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        valid_next   = valid_reg;
        tmo_cnt_next = tmo_cnt_reg;
        done         = 1'b0;
        timeout      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    valid_next   = 1'b1;
                    tmo_cnt_next = '0;
                    state_next   = REQ;
                end
            end
            REQ: begin
                // An ack arriving on the last allowed cycle still completes the transfer.
                if (out_ack) begin
                    valid_next = 1'b0;
                    done       = 1'b1;
                    state_next = RELEASE;
                end else if (TMO_EN) begin
                    if (tmo_cnt_reg == TMO_LAST) begin
                        valid_next = 1'b0;
                        timeout    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (!out_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_valid = valid_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: rtl/nios_pk_output.sv
// Avalon-MM slave that hands a word written by Nios to ReCOP, with sticky
// overrun/timeout status, a transfer counter and a plain PIO fallback mode.
module nios_pk_output
    import nios_pk_pkg::*;
#(
    parameter int   DATA_WIDTH     = 32,
    parameter int   TIMEOUT_CYCLES = 1024,
    parameter logic RESET_HS_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ack
);

    logic wr_en, wr_data, wr_status, wr_control, wr_count;
    logic start, busy, done, timeout;

    logic [DATA_WIDTH-1:0] out_port_reg, out_port_next;
    logic                  hs_en_reg, hs_en_next;
    logic                  ovr_reg, ovr_next;
    logic                  tmo_reg, tmo_next;
    logic [15:0]           count_reg, count_next;
    logic [31:0]           readdata_reg, rd_mux;

    assign wr_en      = chipselect & ~write_n;
    assign wr_data    = wr_en && (address == ADDR_DATA);
    assign wr_status  = wr_en && (address == ADDR_STATUS);
    assign wr_control = wr_en && (address == ADDR_CONTROL);
    assign wr_count   = wr_en && (address == ADDR_COUNT);
    assign start      = wr_data && hs_en_reg && !busy;

    nios_pk_hs_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_hs_fsm (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .out_ack  (out_ack),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    always_comb begin
        out_port_next = out_port_reg;
        hs_en_next    = hs_en_reg;
        ovr_next      = ovr_reg;
        tmo_next      = tmo_reg;
        count_next    = count_reg;

        // Writes while busy are dropped; the stored word is the one on out_port.
        if (wr_data && !busy) begin
            out_port_next = writedata[DATA_WIDTH-1:0];
        end
        if (wr_control) begin
            hs_en_next = writedata[0];
        end

        // Clear first so a same-cycle set takes priority.
        if (wr_status && writedata[ST_OVR]) ovr_next = 1'b0;
        if (wr_status && writedata[ST_TMO]) tmo_next = 1'b0;
        if (wr_data && busy)                ovr_next = 1'b1;
        if (timeout)                        tmo_next = 1'b1;

        if (done)     count_next = count_reg + 16'd1;
        if (wr_count) count_next = '0;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[DATA_WIDTH-1:0] = out_port_reg;
            ADDR_STATUS: begin
                rd_mux[ST_BUSY] = busy;
                rd_mux[ST_OVR]  = ovr_reg;
                rd_mux[ST_TMO]  = tmo_reg;
            end
            ADDR_CONTROL: rd_mux[0] = hs_en_reg;
            ADDR_COUNT:   rd_mux[15:0] = count_reg;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port_reg <= '0;
            hs_en_reg    <= RESET_HS_EN;
            ovr_reg      <= 1'b0;
            tmo_reg      <= 1'b0;
            count_reg    <= '0;
            readdata_reg <= '0;
        end else begin
            out_port_reg <= out_port_next;
            hs_en_reg    <= hs_en_next;
            ovr_reg      <= ovr_next;
            tmo_reg      <= tmo_next;
            count_reg    <= count_next;
            readdata_reg <= rd_mux;
        end
    end

    assign out_port = out_port_reg;
    assign readdata = readdata_reg;

endmodule

// File: tb/tb_nios_pk_output.sv
// Randomized scoreboard bench for nios_pk_output: stimulus pushes expected
// transfers and register reads; monitors pop and compare as the DUT presents them.
module tb_nios_pk_output;
    import nios_pk_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        out_valid;
    logic        out_ack = 1'b0;

    nios_pk_output #(
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TMO),
        .RESET_HS_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .out_valid(out_valid), .out_ack(out_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          len;
    } xfer_t;

    xfer_t       xq[$];
    logic [31:0] rq[$];
    string       rn[$];

    int checks = 0;
    int errors = 0;

    // Reference model of the programmer-visible state
    logic [15:0] m_count = '0;
    logic        m_ovr = 1'b0, m_tmo = 1'b0, m_hs = 1'b1;
    logic [31:0] m_last = '0;

    logic rd_issue = 1'b0;
    logic rd_valid_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Transfer monitor: checks data at the rising edge of out_valid and its high time at the fall.
    logic prev_valid = 1'b0;
    int   hi_len = 0;
    int   exp_len = 0;
    bit   active = 1'b0;
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (xq.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
                active = 1'b0;
            end else begin
                xfer_t e;
                e = xq.pop_front();
                chk("xfer_out_port", out_port, e.data);
                exp_len = e.len;
                active  = 1'b1;
            end
            hi_len = 1;
        end else if (out_valid && prev_valid) begin
            hi_len++;
        end else if (!out_valid && prev_valid && active) begin
            chk("xfer_valid_cycles", 32'(hi_len), 32'(exp_len));
            active = 1'b0;
        end
        prev_valid = out_valid;
    end

    always @(posedge clk) rd_valid_d <= rd_issue;

    always @(negedge clk) begin
        if (rd_valid_d) begin
            if (rq.size() == 0) begin
                chk("unexpected_read", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                string n;
                e = rq.pop_front();
                n = rn.pop_front();
                chk(n, readdata, e);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cyc(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        rq.push_back(exp);
        rn.push_back(name);
        address = a; rd_issue = 1'b1;
        cyc(1);
        rd_issue = 1'b0;
    endtask

    task automatic check_regs();
        rd(ADDR_STATUS,  {29'd0, m_tmo, m_ovr, 1'b0}, "rd_status");
        rd(ADDR_COUNT,   {16'd0, m_count},            "rd_count");
        rd(ADDR_DATA,    m_last,                      "rd_data");
        rd(ADDR_CONTROL, {31'd0, m_hs},               "rd_control");
    endtask

    // Handshaked transfer; ack comes dly cycles after out_valid, or never if dly >= TMO.
    task automatic do_xfer(input logic [31:0] d, input int dly);
        xfer_t e;
        e.data = d;
        e.len  = (dly < TMO) ? dly + 1 : TMO;
        xq.push_back(e);
        if (dly == 0) begin
            out_ack = 1'b1;
            cyc(1);
        end
        wr(ADDR_DATA, d);
        m_last = d;
        if (dly < TMO) begin
            cyc(dly);
            out_ack = 1'b1;
            cyc(1 + $urandom_range(0, 2));
            out_ack = 1'b0;
            cyc(1);
            m_count = m_count + 16'd1;
        end else begin
            cyc(TMO + 1);
            m_tmo = 1'b1;
        end
        check_regs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_port", out_port, 32'd0);
        check_regs();

        do_xfer(32'h0000_00A5, 3);

        // Overrun while in REQ, then clear the overrun bit while still busy.
        begin
            xfer_t e;
            e.data = 32'h0000_00C3; e.len = 6;
            xq.push_back(e);
            wr(ADDR_DATA, 32'h0000_00C3);
            m_last = 32'h0000_00C3;
            wr(ADDR_DATA, 32'h0000_1234);
            m_ovr = 1'b1;
            rd(ADDR_STATUS, 32'h3, "rd_status_overrun");
            wr(ADDR_STATUS, 32'h2);
            m_ovr = 1'b0;
            rd(ADDR_STATUS, 32'h1, "rd_status_ovr_cleared");
            rd(ADDR_DATA, 32'h0000_00C3, "rd_data_after_overrun");
            out_ack = 1'b1;
            cyc(2);
            out_ack = 1'b0;
            cyc(1);
            m_count = m_count + 16'd1;
            check_regs();
        end

        do_xfer($urandom, 20);
        wr(ADDR_STATUS, 32'h4);
        m_tmo = 1'b0;
        do_xfer($urandom, TMO - 1);

        // Direct PIO mode
        wr(ADDR_CONTROL, 32'h0);
        m_hs = 1'b0;
        wr(ADDR_DATA, 32'hFFFF_FFFF);
        m_last = 32'hFFFF_FFFF;
        chk("direct_out_port", out_port, 32'hFFFF_FFFF);
        chk("direct_out_valid", {31'd0, out_valid}, 32'd0);
        cyc(3);
        check_regs();
        wr(ADDR_CONTROL, 32'h1);
        m_hs = 1'b1;

        for (int i = 0; i < 30; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                wr(ADDR_CONTROL, 32'h0);
                wr(ADDR_DATA, $urandom);
                m_last = dut.out_port === 32'hx ? 32'h0 : writedata;
                wr(ADDR_CONTROL, 32'h1);
                check_regs();
            end else if (op == 1) begin
                wr(ADDR_COUNT, $urandom);
                m_count = '0;
                check_regs();
            end else if (op == 2) begin
                wr(ADDR_STATUS, 32'h6);
                m_ovr = 1'b0; m_tmo = 1'b0;
                check_regs();
            end else begin
                do_xfer($urandom, int'($urandom_range(0, 10)));
            end
        end

        // Counter wrap
        @(negedge clk);
        force dut.count_reg = 16'hFFFF;
        cyc(1);
        release dut.count_reg;
        m_count = 16'hFFFF;
        check_regs();
        do_xfer(32'h5A5A_0001, 2);

        // Reset during REQ drops out_valid on the next edge.
        begin
            xfer_t e;
            e.data = 32'hDEAD_BEEF; e.len = 1;
            xq.push_back(e);
            wr(ADDR_DATA, 32'hDEAD_BEEF);
            reset = 1'b1;
            cyc(1);
            chk("reset_mid_out_valid", {31'd0, out_valid}, 32'd0);
            chk("reset_mid_out_port", out_port, 32'd0);
            reset = 1'b0;
            m_count = '0; m_ovr = 1'b0; m_tmo = 1'b0; m_hs = 1'b1; m_last = '0;
            cyc(1);
            check_regs();
        end

        cyc(4);
        chk("xfer_queue_drained", 32'(xq.size()), 32'd0);
        chk("read_queue_drained", 32'(rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
